sound_event_scheduler: RTL and testbench



---
 rtl/sound_event_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sound_event_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_scheduler.sv
// Priority scheduler sharing one tone generator between four game events (two-note jingles timed in frames).
// Optional build macro SOUND_PREEMPT_EN: a higher-priority pending event aborts a playing one.
module sound_event_scheduler #(
  parameter int NOTE_FRAMES = 8,
  parameter int GAP_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [3:0] event_req,
  output logic       sound_en,
  output logic [3:0] freq_idx,
  output logic [1:0] active_id,
  output logic       busy,
  output logic       event_done,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY0, S_PLAY1, S_GAP} state_t;

  localparam logic [5:0] NOTE_LAST = 6'(NOTE_FRAMES - 1);
  localparam logic [5:0] GAP_LAST  = 6'(GAP_FRAMES - 1);

  state_t     r_state, w_state_next;
  logic [5:0] r_cnt, w_cnt_next;
  logic [3:0] r_req_d, r_pending, w_pending_next, w_rise, w_clear;
  logic       r_sound_en, w_sound_en_next;
  logic [3:0] r_freq, w_freq_next;
  logic [1:0] r_id, w_id_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;
  logic       w_any;
  logic [1:0] w_top_id;

  function automatic logic [3:0] note0(input logic [1:0] id);
    case (id)
      2'd0:    note0 = 4'd9;
      2'd1:    note0 = 4'd4;
      2'd2:    note0 = 4'd4;
      default: note0 = 4'd7;
    endcase
  endfunction

  function automatic logic [3:0] note1(input logic [1:0] id);
    case (id)
      2'd0:    note1 = 4'd7;
      2'd1:    note1 = 4'd7;
      2'd2:    note1 = 4'd9;
      default: note1 = 4'd2;
    endcase
  endfunction

  assign w_rise         = event_req & ~r_req_d;
  assign w_pending_next = (r_pending & ~w_clear) | w_rise;
  assign w_any          = |r_pending;

  // Fixed priority: later (higher-index) bits override earlier ones.
  always_comb begin
    w_top_id = 2'd0;
    if (r_pending[1]) w_top_id = 2'd1;
    if (r_pending[2]) w_top_id = 2'd2;
    if (r_pending[3]) w_top_id = 2'd3;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_clear         = 4'd0;
    w_sound_en_next = r_sound_en;
    w_freq_next     = r_freq;
    w_id_next       = r_id;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_clear         = 4'b0001 << w_top_id;
          w_state_next    = S_PLAY0;
          w_cnt_next      = 6'd0;
          w_sound_en_next = 1'b1;
          w_freq_next     = note0(w_top_id);
          w_id_next       = w_top_id;
          w_busy_next     = 1'b1;
        end
      end
      S_PLAY0: begin
        if (startOfFrame) begin
          if (r_cnt == NOTE_LAST) begin
            w_state_next = S_PLAY1;
            w_cnt_next   = 6'd0;
            w_freq_next  = note1(r_id);
          end else begin
            w_cnt_next = r_cnt + 6'd1;
          end
        end
      end
      S_PLAY1: begin
        if (startOfFrame) begin
          if (r_cnt == NOTE_LAST) begin
            w_done_next     = 1'b1;
            w_sound_en_next = 1'b0;
            w_freq_next     = 4'd0;
            w_cnt_next      = 6'd0;
            if (GAP_FRAMES != 0) begin
              w_state_next = S_GAP;
            end else begin
              w_state_next = S_IDLE;
              w_id_next    = 2'd0;
              w_busy_next  = 1'b0;
            end
          end else begin
            w_cnt_next = r_cnt + 6'd1;
          end
        end
      end
      S_GAP: begin
        if (startOfFrame) begin
          if (r_cnt == GAP_LAST) begin
            w_state_next = S_IDLE;
            w_cnt_next   = 6'd0;
            w_id_next    = 2'd0;
            w_busy_next  = 1'b0;
          end else begin
            w_cnt_next = r_cnt + 6'd1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

`ifdef SOUND_PREEMPT_EN
    // Abort overrides any note/frame transition decided above; the aborted event is simply dropped.
    if ((r_state == S_PLAY0 || r_state == S_PLAY1) && w_any && (w_top_id > r_id)) begin
      w_clear         = 4'b0001 << w_top_id;
      w_state_next    = S_PLAY0;
      w_cnt_next      = 6'd0;
      w_sound_en_next = 1'b1;
      w_freq_next     = note0(w_top_id);
      w_id_next       = w_top_id;
      w_busy_next     = 1'b1;
      w_done_next     = 1'b0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_cnt      <= 6'd0;
      r_req_d    <= 4'd0;
      r_pending  <= 4'd0;
      r_sound_en <= 1'b0;
      r_freq     <= 4'd0;
      r_id       <= 2'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_req_d    <= event_req;
      r_pending  <= w_pending_next;
      r_sound_en <= w_sound_en_next;
      r_freq     <= w_freq_next;
      r_id       <= w_id_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign sound_en   = r_sound_en;
  assign freq_idx   = r_freq;
  assign active_id  = r_id;
  assign busy       = r_busy;
  assign event_done = r_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler (NOTE_FRAMES=2; GAP_FRAMES=1 main instance, 0 second instance).
module tb_sound_event_scheduler;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof;
  logic [3:0] event_req, g_req;
  logic       sound_en, busy, event_done;
  logic [3:0] freq_idx, pending;
  logic [1:0] active_id;
  logic       g_sound_en, g_busy, g_done;
  logic [3:0] g_freq, g_pending;
  logic [1:0] g_id;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  sound_event_scheduler #(.NOTE_FRAMES(2), .GAP_FRAMES(1)) u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .event_req(event_req),
    .sound_en(sound_en), .freq_idx(freq_idx), .active_id(active_id),
    .busy(busy), .event_done(event_done), .pending(pending)
  );

  sound_event_scheduler #(.NOTE_FRAMES(2), .GAP_FRAMES(0)) u_gap0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .event_req(g_req),
    .sound_en(g_sound_en), .freq_idx(g_freq), .active_id(g_id),
    .busy(g_busy), .event_done(g_done), .pending(g_pending)
  );

  always @(negedge clk) if (event_done) n_done++;

  typedef struct {
    logic [3:0] req;
    int         id;
    int         n0;
    int         n1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Nine quiet cycles, then one startOfFrame cycle; outputs are checked right after it.
  task automatic frame();
    repeat (9) cyc();
    sof = 1'b1;
    cyc();
    sof = 1'b0;
  endtask

  // Called on the first PLAY0 cycle of an event; runs it through GAP back to IDLE.
  task automatic play_event(input int id, input int n0, input int n1);
    check("play0_en", int'(sound_en), 1);
    check("play0_freq", int'(freq_idx), n0);
    check("play0_id", int'(active_id), id);
    check("play0_busy", int'(busy), 1);
    frame();
    check("note0_hold", int'(freq_idx), n0);
    frame();
    check("note1_freq", int'(freq_idx), n1);
    check("note1_en", int'(sound_en), 1);
    frame();
    check("note1_nodone", int'(event_done), 0);
    frame();
    check("done_pulse", int'(event_done), 1);
    check("gap_en", int'(sound_en), 0);
    check("gap_freq", int'(freq_idx), 0);
    check("gap_busy", int'(busy), 1);
    check("gap_id", int'(active_id), id);
    cyc();
    check("done_one_cycle", int'(event_done), 0);
    frame();
    check("idle_busy", int'(busy), 0);
    check("idle_id", int'(active_id), 0);
    check("idle_en", int'(sound_en), 0);
  endtask

  initial begin
    int done_base;
    int busy_cnt;

    vecs[0] = '{req: 4'b0001, id: 0, n0: 9, n1: 7};
    vecs[1] = '{req: 4'b0010, id: 1, n0: 4, n1: 7};
    vecs[2] = '{req: 4'b0100, id: 2, n0: 4, n1: 9};
    vecs[3] = '{req: 4'b1000, id: 3, n0: 7, n1: 2};

    resetN = 1'b0; sof = 1'b0; event_req = 4'd0; g_req = 4'd0;
    repeat (3) cyc();
    check("rst_en", int'(sound_en), 0);
    check("rst_freq", int'(freq_idx), 0);
    check("rst_id", int'(active_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(event_done), 0);
    check("rst_pending", int'(pending), 0);
    resetN = 1'b1;
    cyc();

    // Single pulse per event, including the two-cycle request-to-sound latency.
    for (int i = 0; i < 4; i++) begin
      event_req = vecs[i].req;
      cyc();
      event_req = 4'd0;
      check("edge_pending", int'(pending), int'(vecs[i].req));
      check("edge_not_yet", int'(sound_en), 0);
      cyc();
      check("grant_clear", int'(pending), 0);
      play_event(vecs[i].id, vecs[i].n0, vecs[i].n1);
      cyc();
    end

    // Simultaneous collision+score+lose: lose, score, collision with one idle cycle between.
    event_req = 4'b1011;
    cyc();
    event_req = 4'd0;
    check("multi_pending", int'(pending), 11);
    cyc();
    check("multi_pending_after", int'(pending), 3);
    play_event(3, 7, 2);
    check("idle_gap_pending", int'(pending), 3);
    cyc();
    play_event(1, 4, 7);
    check("idle_gap_en", int'(sound_en), 0);
    cyc();
    play_event(0, 9, 7);
    check("multi_pending_end", int'(pending), 0);
    cyc();

    // Win held high for 100 frames with three collision pulses during the win event.
    done_base = n_done;
    event_req = 4'b0100;
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      event_req = 4'b0101;
      cyc();
      event_req = 4'b0100;
      cyc();
    end
    check("coll_queued", int'(pending), 1);
    play_event(2, 4, 9);
    cyc();
    play_event(0, 9, 7);
    busy_cnt = 0;
    repeat (890) begin
      cyc();
      if (busy) busy_cnt++;
    end
    check("win_once_busy", busy_cnt, 0);
    check("win_coll_done_count", n_done - done_base, 2);
    event_req = 4'd0;
    cyc();

    // Reset mid-PLAY1 with score and collision queued.
    event_req = 4'b1000;
    cyc();
    event_req = 4'd0;
    cyc();
    event_req = 4'b0011;
    cyc();
    event_req = 4'd0;
    frame();
    frame();
    check("pre_rst_pending", int'(pending), 3);
    check("pre_rst_note1", int'(freq_idx), 2);
    resetN = 1'b0;
    #1;
    check("mid_rst_en", int'(sound_en), 0);
    check("mid_rst_freq", int'(freq_idx), 0);
    check("mid_rst_id", int'(active_id), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pending", int'(pending), 0);
    cyc();
    resetN = 1'b1;
    frame();
    check("post_rst_en", int'(sound_en), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_pending", int'(pending), 0);
    event_req = 4'b0100;
    cyc();
    event_req = 4'd0;
    cyc();
    play_event(2, 4, 9);
    cyc();

    // Lose pulse while collision is in PLAY0.
    done_base = n_done;
    event_req = 4'b0001;
    cyc();
    event_req = 4'd0;
    cyc();
    check("pre_coll_freq", int'(freq_idx), 9);
    event_req = 4'b1000;
    cyc();
    event_req = 4'd0;
`ifdef SOUND_PREEMPT_EN
    cyc();
    check("preempt_freq", int'(freq_idx), 7);
    check("preempt_id", int'(active_id), 3);
    check("preempt_pending", int'(pending), 0);
    play_event(3, 7, 2);
    check("preempt_done_count", n_done - done_base, 1);
`else
    check("nopre_pending", int'(pending), 8);
    check("nopre_id", int'(active_id), 0);
    play_event(0, 9, 7);
    cyc();
    play_event(3, 7, 2);
    check("nopre_done_count", n_done - done_base, 2);
`endif
    cyc();

    // GAP_FRAMES=0 instance: win then score, sound_en low for exactly one cycle between.
    g_req = 4'b0110;
    cyc();
    g_req = 4'd0;
    cyc();
    check("g0_en", int'(g_sound_en), 1);
    check("g0_id", int'(g_id), 2);
    check("g0_freq", int'(g_freq), 4);
    repeat (3) frame();
    check("g0_note1", int'(g_freq), 9);
    frame();
    check("g0_done", int'(g_done), 1);
    check("g0_off", int'(g_sound_en), 0);
    check("g0_idle_busy", int'(g_busy), 0);
    check("g0_idle_id", int'(g_id), 0);
    cyc();
    check("g0_next_en", int'(g_sound_en), 1);
    check("g0_next_id", int'(g_id), 1);
    check("g0_next_freq", int'(g_freq), 4);
    repeat (4) frame();
    check("g0_done2", int'(g_done), 1);
    check("g0_end_busy", int'(g_busy), 0);
    check("g0_end_pending", int'(g_pending), 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
